// File: rtl/ghost_dist_map.sv
// ghost_dist_map: distance-map RAM for the ghost-chase logic.
// Holds |px-x| + |py-y| for every maze cell and rebuilds the whole map
// (one cell per clock, raster order) whenever any watched position changes.
//
// Ports:
//   CLOCK_50                     single clock
//   reset                        synchronous, active-high
//   curr_pacman_x/y              Pac-Man cell
//   curr_ghost{1,2}_x/y          ghost current cells (watched only)
//   prev_ghost{1,2}_x/y          ghost previous cells (watched; penalised when enabled)
//   rdaddr_x/y                   read address
//   data                         registered read data, 255 outside the grid
//   ready                        map complete for the current input snapshot
//
// Optional feature macro: GHOST_MAP_PREV_PENALTY_EN
//   When defined, the cells at prev_ghost1 and prev_ghost2 are written as 255.

module ghost_dist_map #(
  parameter int unsigned GRID_W = 40,
  parameter int unsigned GRID_H = 30
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [5:0] curr_pacman_x,
  input  logic [4:0] curr_pacman_y,
  input  logic [5:0] curr_ghost1_x,
  input  logic [4:0] curr_ghost1_y,
  input  logic [5:0] curr_ghost2_x,
  input  logic [4:0] curr_ghost2_y,
  input  logic [5:0] prev_ghost1_x,
  input  logic [4:0] prev_ghost1_y,
  input  logic [5:0] prev_ghost2_x,
  input  logic [4:0] prev_ghost2_y,
  input  logic [5:0] rdaddr_x,
  input  logic [4:0] rdaddr_y,
  output logic [7:0] data,
  output logic       ready
);

  localparam int unsigned XW    = 6;
  localparam int unsigned YW    = 5;
  localparam int unsigned AW    = XW + YW;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [XW-1:0] LAST_X = XW'(GRID_W - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(GRID_H - 1);
  localparam logic [DW-1:0] FAR    = '1;

  typedef struct packed {
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [XW-1:0] g1x;
    logic [YW-1:0] g1y;
    logic [XW-1:0] g2x;
    logic [YW-1:0] g2y;
    logic [XW-1:0] pg1x;
    logic [YW-1:0] pg1y;
    logic [XW-1:0] pg2x;
    logic [YW-1:0] pg2y;
  } pos_t;

  typedef enum logic {
    S_SWEEP = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  pos_t          r_snap;
  pos_t          w_live;
  logic [XW-1:0] r_x, w_x_nxt;
  logic [YW-1:0] r_y, w_y_nxt;
  logic          r_ready, w_ready_nxt;
  logic          w_we;
  logic          w_change;
  logic [XW-1:0] w_dx;
  logic [YW-1:0] w_dy;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_mem [DEPTH];

  // Live view of every watched position input
  assign w_live = '{px:   curr_pacman_x, py:   curr_pacman_y,
                    g1x:  curr_ghost1_x, g1y:  curr_ghost1_y,
                    g2x:  curr_ghost2_x, g2y:  curr_ghost2_y,
                    pg1x: prev_ghost1_x, pg1y: prev_ghost1_y,
                    pg2x: prev_ghost2_x, pg2y: prev_ghost2_y};

  assign w_change = (w_live != r_snap);

  // Next-state / sweep address / ready; a change overrides sweep completion
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_we        = 1'b0;
    w_ready_nxt = 1'b0;
    case (r_state)
      S_SWEEP: begin
        w_we = 1'b1;
        if (r_x == LAST_X && r_y == LAST_Y) begin
          w_state_nxt = S_IDLE;
        end else if (r_x == LAST_X) begin
          w_x_nxt = '0;
          w_y_nxt = r_y + YW'(1);
        end else begin
          w_x_nxt = r_x + XW'(1);
        end
      end
      S_IDLE: begin
        w_we = 1'b0;
      end
      default: begin
        w_state_nxt = S_SWEEP;
      end
    endcase
    if (w_change) begin
      w_state_nxt = S_SWEEP;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
    end
    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  // State, sweep address, snapshot and ready registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_SWEEP;
      r_x     <= '0;
      r_y     <= '0;
      r_snap  <= w_live;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_ready <= w_ready_nxt;
      if (w_change) begin
        r_snap <= w_live;
      end
    end
  end

  // Manhattan distance of the sweep cell, taken from the snapshot
  always_comb begin
    w_dx    = (r_snap.px >= r_x) ? (r_snap.px - r_x) : (r_x - r_snap.px);
    w_dy    = (r_snap.py >= r_y) ? (r_snap.py - r_y) : (r_y - r_snap.py);
    w_wdata = DW'(w_dx) + DW'(w_dy);
`ifdef GHOST_MAP_PREV_PENALTY_EN
    // Off-grid prev cells never match because the sweep stays inside the grid
    if ((r_x == r_snap.pg1x && r_y == r_snap.pg1y) ||
        (r_x == r_snap.pg2x && r_y == r_snap.pg2y)) begin
      w_wdata = FAR;
    end
`endif
  end

  // Map RAM write port (not reset; every cell is rewritten by the sweep)
  always_ff @(posedge CLOCK_50) begin
    if (w_we) begin
      r_mem[{r_y, r_x}] <= w_wdata;
    end
  end

  // Registered read port; off-grid addresses (including wrapped -1) read 255
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_data <= FAR;
    end else if (32'(rdaddr_x) >= GRID_W || 32'(rdaddr_y) >= GRID_H) begin
      r_data <= FAR;
    end else begin
      r_data <= r_mem[{rdaddr_y, rdaddr_x}];
    end
  end

  assign data  = r_data;
  assign ready = r_ready;

endmodule

// File: tb/tb_ghost_dist_map.sv
// Directed bench for ghost_dist_map: read tables after each full sweep plus
// hand-written sequences for reset, change, mid-sweep restart and last-cell change.
module tb_ghost_dist_map;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [5:0] curr_pacman_x, curr_ghost1_x, curr_ghost2_x, prev_ghost1_x, prev_ghost2_x, rdaddr_x;
  logic [4:0] curr_pacman_y, curr_ghost1_y, curr_ghost2_y, prev_ghost1_y, prev_ghost2_y, rdaddr_y;
  logic [7:0] data;
  logic       ready;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0] x;
    logic [4:0] y;
    logic [7:0] exp;
  } rd_vec_t;

  ghost_dist_map dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .curr_pacman_x (curr_pacman_x),
    .curr_pacman_y (curr_pacman_y),
    .curr_ghost1_x (curr_ghost1_x),
    .curr_ghost1_y (curr_ghost1_y),
    .curr_ghost2_x (curr_ghost2_x),
    .curr_ghost2_y (curr_ghost2_y),
    .prev_ghost1_x (prev_ghost1_x),
    .prev_ghost1_y (prev_ghost1_y),
    .prev_ghost2_x (prev_ghost2_x),
    .prev_ghost2_y (prev_ghost2_y),
    .rdaddr_x      (rdaddr_x),
    .rdaddr_y      (rdaddr_y),
    .data          (data),
    .ready         (ready)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Edges until ready rises, bounded
  task automatic cycles_to_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
  endtask

  // Back-to-back reads, one per cycle, each checked one edge after presentation
  task automatic run_reads(input string tag, input rd_vec_t v[$]);
    foreach (v[i]) begin
      rdaddr_x = v[i].x;
      rdaddr_y = v[i].y;
      tick();
      check($sformatf("%s rd(%0d,%0d)", tag, v[i].x, v[i].y), data, v[i].exp);
    end
  endtask

  initial begin
    rd_vec_t t_pow[$];
    rd_vec_t t_p55[$];
    rd_vec_t t_p103[$];
    int n;
    logic [7:0] exp_pen;

`ifdef GHOST_MAP_PREV_PENALTY_EN
    exp_pen = 8'd255;
`else
    exp_pen = 8'd12;
`endif

    // Pac-Man at (20,20)
    t_pow.push_back('{6'd20, 5'd20, 8'd0});
    t_pow.push_back('{6'd16, 5'd12, exp_pen});
    t_pow.push_back('{6'd17, 5'd12, 8'd11});
    t_pow.push_back('{6'd0,  5'd0,  8'd40});
    t_pow.push_back('{6'd63, 5'd13, 8'd255});
    t_pow.push_back('{6'd16, 5'd31, 8'd255});
    t_pow.push_back('{6'd40, 5'd0,  8'd255});
    t_pow.push_back('{6'd39, 5'd29, 8'd28});
    t_pow.push_back('{6'd19, 5'd20, 8'd1});
    t_pow.push_back('{6'd21, 5'd20, 8'd1});
    t_pow.push_back('{6'd20, 5'd19, 8'd1});
    // Pac-Man at (5,5)
    t_p55.push_back('{6'd5,  5'd5,  8'd0});
    t_p55.push_back('{6'd20, 5'd20, 8'd30});
    t_p55.push_back('{6'd0,  5'd0,  8'd10});
    t_p55.push_back('{6'd39, 5'd29, 8'd58});
    // Pac-Man at (10,3)
    t_p103.push_back('{6'd10, 5'd3,  8'd0});
    t_p103.push_back('{6'd0,  5'd0,  8'd13});
    t_p103.push_back('{6'd39, 5'd29, 8'd55});

    reset = 1'b1;
    curr_pacman_x = 6'd20; curr_pacman_y = 5'd20;
    curr_ghost1_x = 6'd1;  curr_ghost1_y = 5'd1;
    curr_ghost2_x = 6'd30; curr_ghost2_y = 5'd25;
    prev_ghost1_x = 6'd16; prev_ghost1_y = 5'd12;
    prev_ghost2_x = 6'd45; prev_ghost2_y = 5'd3;
    rdaddr_x = 6'd20; rdaddr_y = 5'd20;

    // Power-on reset
    tick(); tick();
    check("reset ready", ready, 1'b0);
    check("reset data", data, 8'd255);
    reset = 1'b0;
    cycles_to_ready(n);
    check("power-on sweep cycles", n, 1200);
    run_reads("pow", t_pow);
    check("ready held idle", ready, 1'b1);

    // Pac-Man moves while ready
    curr_pacman_x = 6'd5; curr_pacman_y = 5'd5;
    tick();
    check("ready drop on move", ready, 1'b0);
    cycles_to_ready(n);
    check("move sweep cycles", n, 1200);
    run_reads("p55", t_p55);

    // Change on a prev-ghost input alone still triggers a rebuild
    prev_ghost2_x = 6'd46;
    tick();
    check("ready drop on prev change", ready, 1'b0);
    cycles_to_ready(n);
    check("prev change sweep cycles", n, 1200);

    // Change at cycle 600 of a sweep restarts from (0,0)
    curr_pacman_x = 6'd20; curr_pacman_y = 5'd20;
    tick();
    repeat (599) tick();
    check("ready low mid-sweep", ready, 1'b0);
    curr_pacman_x = 6'd10; curr_pacman_y = 5'd3;
    tick();
    cycles_to_ready(n);
    check("mid-sweep change cycles", n, 1200);
    run_reads("p103", t_p103);

    // Reset at cycle 300 of a sweep
    curr_pacman_x = 6'd20; curr_pacman_y = 5'd20;
    tick();
    repeat (299) tick();
    reset = 1'b1;
    tick();
    check("mid reset ready", ready, 1'b0);
    check("mid reset data", data, 8'd255);
    reset = 1'b0;
    cycles_to_ready(n);
    check("mid reset sweep cycles", n, 1200);
    run_reads("rst", t_pow);

    // Change arriving on the last-cell write edge wins over completion
    curr_pacman_x = 6'd5; curr_pacman_y = 5'd5;
    tick();
    repeat (1199) tick();
    check("ready low before last cell", ready, 1'b0);
    curr_pacman_x = 6'd10; curr_pacman_y = 5'd3;
    tick();
    check("ready low after last-cell change", ready, 1'b0);
    cycles_to_ready(n);
    check("last-cell change sweep cycles", n, 1200);
    run_reads("last", t_p103);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ghost_dist_map.md
# ghost_dist_map

Distance-map RAM for the ghost-chase logic. It holds, for every maze grid cell, the cell's Manhattan distance from Pac-Man, and rebuilds the whole map whenever Pac-Man or a ghost moves. The ghost location controller reads the four neighbours of each ghost through a one-cycle-latency read port and steps toward the smallest value. `ready` tells that controller when the map is complete and consistent.

## Interface

Parameters:
- `GRID_W`, default 40: grid width in cells; valid x is 0..GRID_W-1.
- `GRID_H`, default 30: grid height in cells; valid y is 0..GRID_H-1.

Ports:
- `CLOCK_50`, in, 1: the single clock.
- `reset`, in, 1: reset, synchronous and active-high.
- `curr_pacman_x`, in, 6: Pac-Man cell x.
- `curr_pacman_y`, in, 5: Pac-Man cell y.
- `curr_ghost1_x`, in, 6, and `curr_ghost1_y`, in, 5: ghost 1 current cell.
- `curr_ghost2_x`, in, 6, and `curr_ghost2_y`, in, 5: ghost 2 current cell.
- `prev_ghost1_x`, in, 6, and `prev_ghost1_y`, in, 5: ghost 1 previous cell.
- `prev_ghost2_x`, in, 6, and `prev_ghost2_y`, in, 5: ghost 2 previous cell.
- `rdaddr_x`, in, 6, and `rdaddr_y`, in, 5: read address.
- `data`, out, 8: registered read data.
- `ready`, out, 1: high when the map is complete for the current input snapshot.

## Operation

Storage:
- 2048 x 8 RAM, addressed by {y, x} (11 bits).
- One write port, driven by the sweep engine.
- One synchronous read port.

Watched inputs:
- The 10 position inputs (Pac-Man, both ghost current cells, both ghost previous cells) are captured in a snapshot register.
- Any mismatch between the live inputs and the snapshot is a "change".

Sweep FSM, two states:
- SWEEP:
  - One cell is written per cycle, raster order: x increments fastest, then y; (0,0) first, (GRID_W-1, GRID_H-1) last.
  - The value written is computed from the snapshot, not the live inputs.
  - After the last cell is written, the FSM goes to IDLE.
- IDLE: holds the map; no writes.
- From any state, a change:
  - reloads the snapshot;
  - resets the sweep address to (0,0);
  - enters SWEEP.
  - A change always wins over sweep completion, including a change arriving on the last-cell cycle.

Cell value:
- |px - x| + |py - y|, computed at 7-bit or wider unsigned precision.
- The maximum is 68 with the default parameters, so no saturation is needed below 255.
- With the previous-cell penalty enabled (see Configuration), the cells at `prev_ghost1` and `prev_ghost2` are written as 255.

Read path:
- `data` is registered from `rdaddr_*`.
- If `rdaddr_x >= GRID_W` or `rdaddr_y >= GRID_H`, `data` is 255.
  - This covers underflow wrap: x-1 from 0 gives 63, y-1 from 0 gives 31.
- Reads during SWEEP are allowed but return undefined or partial map data; `ready` is low in that case.

`ready`:
- High only in IDLE with no pending change.
- Deasserted on the edge after a change is detected.

## Timing

Reset:
- On reset: FSM enters SWEEP, address set to (0,0), snapshot loaded from the live inputs, `ready` = 0, `data` = 255.
- The first cell write happens on the first edge with `reset` low.
- `ready` goes high after the GRID_W*GRID_H-th write edge (1200 cycles with the defaults).

Read latency:
- Exactly one cycle: `rdaddr` is presented at edge N and `data` is valid after edge N+1.
- Back-to-back reads: one per cycle.

Change handling:
- A change detected at edge N gives `ready` = 0 after edge N.
- The full map is rewritten over the next GRID_W*GRID_H cycles.
- A change mid-sweep restarts the sweep from (0,0); there is no partial reuse.

Reset mid-sweep: identical to power-on reset.

The RAM is not cleared on reset; the sweep overwrites every cell.

## Configuration

- `GHOST_MAP_PREV_PENALTY_EN` defined:
  - The cells at `prev_ghost1` and `prev_ghost2` are written as 255, so ghosts never reverse direction.
  - A prev-cell that lies outside the grid is ignored.
- Not defined:
  - Every cell holds its plain Manhattan distance.
  - The prev-ghost inputs are still watched for changes.

## Test plan

- Power-on: reset, then Pac-Man at (20,20), ghosts fixed.
  - `ready` stays 0 for 1199 cycles and is 1 after cycle 1200.
  - Reads return (20,20) -> 0, (16,12) -> 12, (0,0) -> 40.
- Out-of-range reads after `ready`: (63,13) -> 255, (16,31) -> 255, (40,0) -> 255, (39,29) -> 28.
- Pac-Man moves to (5,5) while `ready` is high.
  - `ready` is 0 the next cycle and high again 1200 cycles later.
  - Then (5,5) -> 0 and (20,20) -> 30.
- Macro defined, `prev_ghost1` = (16,12), Pac-Man at (20,20): (16,12) -> 255 and (17,12) -> 11. Without the macro: (16,12) -> 12.
- Mid-sweep events, Pac-Man at (20,20):
  - Pac-Man change at cycle 600 of the sweep: `ready` stays low until 1200 cycles after the change.
  - Reset at cycle 300 of the sweep: `ready` stays low until 1200 cycles after reset release.
- Read latency: change `rdaddr` every cycle across (19,20), (21,20), (20,19). `data` follows one cycle later: 1, 1, 1.
